cpu6_muldiv_seq: RTL and testbench
==================================

# cpu6_muldiv_seq

Iterative multiply/divide sequencer for the cpu6 execute stage. Accepts one M-extension operation at a time and computes it over 32 iterations, driving the shared cpu6 ALU's add and subtract operations instead of owning its own adder. It sits beside the ALU in EX and stalls the pipeline through `req_ready` and `busy` until the result handshake completes.

## Interface
Parameters:
- `CPU6_XLEN` (define), 32: operand/result width; iteration count equals `CPU6_XLEN`.
- `CPU6_ALUCONTROL_SIZE` (define): width of `alu_control`.

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `req_a`, `req_b` in XLEN: rs1, rs2.
- `resp_valid` out 1: result held until accepted.
- `resp_ready` in 1: consumer accepts.
- `resp_data` out XLEN: result.
- `kill` in 1: pipeline flush; aborts any in-flight operation.
- `busy` out 1: state != IDLE.
- `alu_a`, `alu_b` out XLEN: shared ALU operands.
- `alu_control` out ALUCONTROL_SIZE: `CPU6_ALUCONTROL_ADD` or `CPU6_ALUCONTROL_SUB`.
- `alu_y` in XLEN: ALU result.
- `alu_lt` in 1: ALU unsigned a<b, valid for any control.

## Operation
- States: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE: `req_valid & req_ready` latches op/operands and goes to PREP.
- PREP (1 cycle):
  - Take magnitudes of signed operands and record the result sign.
  - Clear the accumulator and load the iteration counter with 31.
  - Divide-by-zero goes directly to DONE with quotient all-ones and remainder = `req_a`.
  - Otherwise go to ITER.
- ITER, multiply:
  - `alu_a` = acc_hi; `alu_b` = multiplicand if multiplier LSB is 1, else 0; control ADD.
  - Carry = (`alu_y` < acc_hi), computed locally.
  - {acc_hi, multiplier} ← {carry, `alu_y`, multiplier[31:1]}.
- ITER, divide (restoring):
  - `alu_a` = {rem[30:0], dividend MSB}; `alu_b` = divisor; control SUB.
  - If `!alu_lt`: rem ← `alu_y`, quotient bit 1.
  - Else: rem ← `alu_a`, quotient bit 0.
  - Shift dividend/quotient left.
- ITER counter:
  - Decrement each cycle.
  - Counter 0 → FIXUP.
- FIXUP (1 cycle):
  - Negate the result if its sign flag is set.
  - Quotient sign = sign(a) ^ sign(b); remainder sign = sign(a).
  - Select the low word (MUL, DIV*, REM*) or high word (MULH*).
  - Go to DONE.
- DONE:
  - `resp_valid` = 1 and `resp_data` stable.
  - `resp_ready` returns to IDLE on the same edge.
  - `req_ready` rises the next cycle; no back-to-back accept in the DONE cycle.
- Signed overflow (DIV −2^31 / −1): quotient 0x80000000, REM 0. This falls out of the negation naturally and needs no special case.
- `kill` wins over every other event, including DONE with `resp_ready`: next state IDLE, `resp_valid` low next cycle, latched result discarded. In IDLE, `kill` also blocks acceptance that cycle.
- ALU drive outside ITER: `alu_a` = `alu_b` = 0, control ADD.

## Timing
- Reset: state IDLE, `req_ready` 1, `busy` 0, `resp_valid` 0, `resp_data` 0, `alu_a`/`alu_b` 0, `alu_control` ADD; all internal registers cleared.
- Reset mid-operation behaves like `kill`.
- Normal latency: accept edge at cycle 0, PREP in cycle 1, ITER in cycles 2–33, FIXUP in cycle 34, `resp_valid` high from cycle 35.
- Divide-by-zero: `resp_valid` high from cycle 2.
- `alu_y` and `alu_lt` are used combinationally in the same cycle the operands are driven; one ALU evaluation per ITER cycle.
- `busy` is high from cycle 1 until the cycle after the response handshake.

## Configuration
- `CPU6_MULDIV_SIGNED_EN` defined: full signed support (MULH, MULHSU, DIV, REM) as above.
- Not defined:
  - Sign handling and negation logic are removed.
  - Ops 001/010 execute as MULHU; 100/110 execute as DIVU/REMU.
  - Latency is unchanged: PREP and FIXUP still take one cycle each.

## Test plan
- MUL 7×6: `resp_data`=42, `resp_valid` exactly 35 cycles after accept.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. With signed enabled, MULH 0xFFFFFFFF×0xFFFFFFFF (−1×−1) → 0x00000000.
- DIVU 100/7 → 14 and REMU 100/7 → 2. With signed enabled: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, `resp_valid` at cycle 2. With signed enabled, DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- Hold `resp_ready`=0 for 10 cycles at DONE: `resp_data` is stable and `req_ready` stays 0. Raise `resp_ready`: IDLE next cycle.
- Assert `kill` in ITER cycle 10: IDLE next cycle, no `resp_valid`. A new MUL 3×3 then returns 9 with normal latency.

Source files
------------

// File: rtl/cpu6_muldiv_seq.sv
// cpu6_muldiv_seq -- iterative multiply/divide sequencer for the cpu6 EX stage.
//
// Computes one M-extension operation over CPU6_XLEN iterations.  It owns no
// adder: every iteration borrows the shared cpu6 ALU (ADD for multiply
// partial sums, SUB for restoring-divide trial subtraction).
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op[2:0]           MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   req_a, req_b          rs1, rs2
//   resp_valid/resp_ready response handshake, resp_data held until accepted
//   kill                  pipeline flush, aborts everything (highest priority)
//   busy                  high whenever not IDLE
//   alu_a, alu_b          shared ALU operands (zero outside ITER)
//   alu_control           shared ALU operation (ADD or SUB)
//   alu_y, alu_lt         shared ALU result and unsigned a<b flag
//
// Configuration macro: CPU6_MULDIV_SIGNED_EN.  When defined, signed ops
// (MULH, MULHSU, DIV, REM) are fully supported.  When undefined, operand
// sign handling and result negation are removed and the signed ops execute
// as their unsigned counterparts with identical latency.

`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_ALUCONTROL_SIZE
`define CPU6_ALUCONTROL_SIZE 4
`endif
`ifndef CPU6_ALUCONTROL_ADD
`define CPU6_ALUCONTROL_ADD 0
`endif
`ifndef CPU6_ALUCONTROL_SUB
`define CPU6_ALUCONTROL_SUB 1
`endif

module cpu6_muldiv_seq (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [2:0]                       req_op,
    input  logic [`CPU6_XLEN-1:0]            req_a,
    input  logic [`CPU6_XLEN-1:0]            req_b,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [`CPU6_XLEN-1:0]            resp_data,
    input  logic                             kill,
    output logic                             busy,
    output logic [`CPU6_XLEN-1:0]            alu_a,
    output logic [`CPU6_XLEN-1:0]            alu_b,
    output logic [`CPU6_ALUCONTROL_SIZE-1:0] alu_control,
    input  logic [`CPU6_XLEN-1:0]            alu_y,
    input  logic                             alu_lt
);
    localparam int XLEN = `CPU6_XLEN;
    localparam int ALUW = `CPU6_ALUCONTROL_SIZE;
    localparam int CNTW = $clog2(XLEN);
    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(`CPU6_ALUCONTROL_ADD);
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(`CPU6_ALUCONTROL_SUB);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_ITER  = 3'd2;
    localparam logic [2:0] S_FIXUP = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state_reg;
    logic [2:0]      op_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    // hi_reg: multiply accumulator high half / divide partial remainder
    // lo_reg: multiplier shifting out    / dividend shifting into quotient
    // opb_reg: multiplicand / divisor magnitude
    logic [XLEN-1:0] hi_reg;
    logic [XLEN-1:0] lo_reg;
    logic [XLEN-1:0] opb_reg;
    logic [CNTW-1:0] cnt_reg;
    logic [XLEN-1:0] result_reg;

    logic is_div, is_rem, mul_high;
    assign is_div   = op_reg[2];
    assign is_rem   = op_reg[2] & op_reg[1];
    assign mul_high = ~op_reg[2] & (op_reg[1] | op_reg[0]);

    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_fix;

`ifdef CPU6_MULDIV_SIGNED_EN
    logic a_signed, b_signed, sign_a, sign_b, res_neg, neg_reg;
    assign a_signed = (op_reg == 3'b001) | (op_reg == 3'b010) |
                      (op_reg == 3'b100) | (op_reg == 3'b110);
    assign b_signed = (op_reg == 3'b001) | (op_reg == 3'b100) | (op_reg == 3'b110);
    assign sign_a   = a_signed & a_reg[XLEN-1];
    assign sign_b   = b_signed & b_reg[XLEN-1];
    assign mag_a    = sign_a ? -a_reg : a_reg;
    assign mag_b    = sign_b ? -b_reg : b_reg;
    // Remainder takes the dividend's sign; everything else the product sign.
    assign res_neg  = is_rem ? sign_a : (sign_a ^ sign_b);
    assign prod_fix = neg_reg ? -{hi_reg, lo_reg} : {hi_reg, lo_reg};
    assign div_fix  = neg_reg ? -(is_rem ? hi_reg : lo_reg) : (is_rem ? hi_reg : lo_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            neg_reg <= 1'b0;
        end else if (state_reg == S_PREP) begin
            neg_reg <= res_neg;
        end
    end
`else
    assign mag_a    = a_reg;
    assign mag_b    = b_reg;
    assign prod_fix = {hi_reg, lo_reg};
    assign div_fix  = is_rem ? hi_reg : lo_reg;
`endif

    logic [XLEN-1:0] fix_word;
    assign fix_word = is_div   ? div_fix :
                      mul_high ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

    // Shared ALU drive: only active during ITER.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        if (state_reg == S_ITER) begin
            if (is_div) begin
                alu_a       = {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
                alu_b       = opb_reg;
                alu_control = ALU_SUB;
            end else begin
                alu_a = hi_reg;
                alu_b = lo_reg[0] ? opb_reg : '0;
            end
        end
    end

    logic mul_carry, div_qbit;
    assign mul_carry = (alu_y < hi_reg);
    // The shifted partial remainder is really XLEN+1 bits wide.  When the
    // bit shifted out of hi_reg is set the value exceeds any divisor, so the
    // subtraction always succeeds and alu_y's low bits are still exact.
    assign div_qbit  = hi_reg[XLEN-1] | ~alu_lt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opb_reg    <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else if (kill) begin
            state_reg  <= S_IDLE;
            result_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        op_reg    <= req_op;
                        a_reg     <= req_a;
                        b_reg     <= req_b;
                        state_reg <= S_PREP;
                    end
                end
                S_PREP: begin
                    hi_reg  <= '0;
                    lo_reg  <= mag_a;
                    opb_reg <= mag_b;
                    cnt_reg <= CNTW'(XLEN - 1);
                    if (is_div && (b_reg == '0)) begin
                        result_reg <= is_rem ? a_reg : '1;
                        state_reg  <= S_DONE;
                    end else begin
                        state_reg <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (is_div) begin
                        hi_reg <= div_qbit ? alu_y : alu_a;
                        lo_reg <= {lo_reg[XLEN-2:0], div_qbit};
                    end else begin
                        hi_reg <= {mul_carry, alu_y[XLEN-1:1]};
                        lo_reg <= {alu_y[0], lo_reg[XLEN-1:1]};
                    end
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) state_reg <= S_FIXUP;
                end
                S_FIXUP: begin
                    result_reg <= fix_word;
                    state_reg  <= S_DONE;
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state_reg  <= S_IDLE;
                        result_reg <= '0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_reg == S_IDLE);
    assign busy       = (state_reg != S_IDLE);
    assign resp_valid = (state_reg == S_DONE);
    assign resp_data  = resp_valid ? result_reg : '0;

endmodule

// File: tb/tb_cpu6_muldiv_seq.sv
// Self-checking bench for cpu6_muldiv_seq: a table of directed operations
// with hand-computed results and latencies, plus hand-written sequences for
// response back-pressure, kill and reset corner cases.  The shared ALU is
// modelled here from its definition (add/sub, unsigned less-than).

`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif
`ifndef CPU6_ALUCONTROL_SIZE
`define CPU6_ALUCONTROL_SIZE 4
`endif
`ifndef CPU6_ALUCONTROL_ADD
`define CPU6_ALUCONTROL_ADD 0
`endif
`ifndef CPU6_ALUCONTROL_SUB
`define CPU6_ALUCONTROL_SUB 1
`endif

module tb_cpu6_muldiv_seq;
    localparam int ALUW = `CPU6_ALUCONTROL_SIZE;
    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(`CPU6_ALUCONTROL_ADD);
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(`CPU6_ALUCONTROL_SUB);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_op = 3'd0;
    logic [31:0]     req_a = '0;
    logic [31:0]     req_b = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [31:0]     resp_data;
    logic            kill = 1'b0;
    logic            busy;
    logic [31:0]     alu_a, alu_b, alu_y;
    logic [ALUW-1:0] alu_control;
    logic            alu_lt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    assign alu_y  = (alu_control == ALU_SUB) ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_lt = (alu_a < alu_b);

    cpu6_muldiv_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .kill(kill), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_y(alu_y), .alu_lt(alu_lt)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Present a request and return #1 after the accepting edge (state PREP).
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("req_ready before accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Count cycles from accept until resp_valid; the PREP cycle is cycle 1.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("busy after handshake", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic seen;

        // Table: name, op, a, b, expected result, expected latency.
        vecs.push_back('{"MUL 7x6",          3'b000, 32'd7,        32'd6,        32'd42,       35});
        vecs.push_back('{"MULHU -1x-1",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35});
        vecs.push_back('{"MUL wrap",         3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 35});
        vecs.push_back('{"MULHU 2^31x4",     3'b011, 32'h80000000, 32'd4,        32'd2,        35});
        vecs.push_back('{"DIVU 100/7",       3'b101, 32'd100,      32'd7,        32'd14,       35});
        vecs.push_back('{"REMU 100/7",       3'b111, 32'd100,      32'd7,        32'd2,        35});
        vecs.push_back('{"DIVU 5/0",         3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2});
        vecs.push_back('{"REMU 5/0",         3'b111, 32'd5,        32'd0,        32'd5,        2});
        vecs.push_back('{"DIVU big divisor", 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        35});
        vecs.push_back('{"REMU big divisor", 3'b111, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        35});
`ifdef CPU6_MULDIV_SIGNED_EN
        vecs.push_back('{"MULH -1x-1",       3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35});
        vecs.push_back('{"MULHSU -1xmax",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35});
        vecs.push_back('{"DIV -7/2",         3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35});
        vecs.push_back('{"REM -7/2",         3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 35});
        vecs.push_back('{"DIV overflow",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35});
        vecs.push_back('{"REM overflow",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 35});
        vecs.push_back('{"REM -7/0",         3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 2});
`else
        vecs.push_back('{"MULH as MULHU",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35});
        vecs.push_back('{"MULHSU as MULHU",  3'b010, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 35});
        vecs.push_back('{"DIV as DIVU",      3'b100, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 35});
        vecs.push_back('{"REM as REMU",      3'b110, 32'hFFFFFFF9, 32'd2,        32'd1,        35});
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset req_ready",   {31'd0, req_ready},  32'd1);
        check("reset busy",        {31'd0, busy},       32'd0);
        check("reset resp_valid",  {31'd0, resp_valid}, 32'd0);
        check("reset resp_data",   resp_data,           32'd0);
        check("reset alu_a",       alu_a,               32'd0);
        check("reset alu_b",       alu_b,               32'd0);
        check("reset alu_control", 32'(alu_control),    32'(ALU_ADD));

        // Table-driven operations
        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_resp(lat);
            check({vecs[i].name, " data"}, resp_data, vecs[i].exp);
            check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
            $display("op %s: a=0x%08h b=0x%08h -> 0x%08h (exp 0x%08h) after %0d cycles",
                     vecs[i].name, vecs[i].a, vecs[i].b, resp_data, vecs[i].exp, lat);
            handshake();
        end

        // ALU drive in PREP and during a divide iteration
        start_op(3'b101, 32'd100, 32'd7);
        check("prep alu_b", alu_b, 32'd0);
        check("prep alu_control", 32'(alu_control), 32'(ALU_ADD));
        @(posedge clk); #1;
        check("div iter alu_b", alu_b, 32'd7);
        check("div iter alu_control", 32'(alu_control), 32'(ALU_SUB));
        wait_resp(lat);
        check("DIVU 100/7 again data", resp_data, 32'd14);
        $display("op DIVU 100/7 with ALU probes -> 0x%08h after %0d cycles", resp_data, lat);
        handshake();

        // Back-pressure at DONE for 10 cycles
        start_op(3'b000, 32'd7, 32'd6);
        wait_resp(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("stall resp_data", resp_data, 32'd42);
            check("stall req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post-stall req_ready",  {31'd0, req_ready},  32'd1);
        check("post-stall resp_valid", {31'd0, resp_valid}, 32'd0);
        $display("op MUL 7x6 held 10 cycles at DONE, released");

        // Kill in ITER cycle 10 (overall cycle 11)
        start_op(3'b000, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1;
        check("pre-kill busy", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill req_ready",  {31'd0, req_ready},  32'd1);
        check("kill busy",       {31'd0, busy},       32'd0);
        check("kill resp_valid", {31'd0, resp_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check("no resp after kill", {31'd0, seen}, 32'd0);
        start_op(3'b000, 32'd3, 32'd3);
        wait_resp(lat);
        check("MUL 3x3 after kill data", resp_data, 32'd9);
        check("MUL 3x3 after kill latency", 32'(lat), 32'd35);
        $display("op MUL 3x5 killed in ITER; MUL 3x3 -> 0x%08h after %0d cycles", resp_data, lat);
        handshake();

        // Kill beats a DONE handshake and discards the result
        start_op(3'b000, 32'd2, 32'd2);
        wait_resp(lat);
        kill = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; resp_ready = 1'b0;
        check("kill at DONE resp_valid", {31'd0, resp_valid}, 32'd0);
        check("kill at DONE resp_data",  resp_data,           32'd0);
        $display("op MUL 2x2 killed at DONE");

        // Kill in IDLE blocks acceptance
        req_valid = 1'b1; req_op = 3'b000; req_a = 32'd1; req_b = 32'd1; kill = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; kill = 1'b0;
        check("kill in IDLE busy", {31'd0, busy}, 32'd0);
        $display("op request with kill in IDLE not accepted");

        // Reset mid-operation
        start_op(3'b101, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid-op reset busy",       {31'd0, busy},       32'd0);
        check("mid-op reset resp_valid", {31'd0, resp_valid}, 32'd0);
        $display("op DIVU aborted by reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
